// File: rtl/phase_bcd_counter.sv
// phase_bcd_counter: 3-digit BCD count step driven by a 5-phase one-hot sequencer.
// Build option: CNT_DOWN_EN adds dn for down counting with borrow.
//
// Ports:
//   CLK            rising-edge clock
//   RST            synchronous active-high reset
//   ph[4:0]        one-hot phase (0 = idle)
//   clr            synchronous clear of count and flags
//   dn             count direction, only with CNT_DOWN_EN (1 = down)
//   disp_h/t/o     latched BCD display digits
//   wrap           one-cycle pulse after the wrapping ph[3]
//   err            sticky multi-hot phase flag
module phase_bcd_counter #(
  parameter int TERM = 499
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] ph,
  input  logic       clr,
`ifdef CNT_DOWN_EN
  input  logic       dn,
`endif
  output logic [3:0] disp_h,
  output logic [3:0] disp_t,
  output logic [3:0] disp_o,
  output logic       wrap,
  output logic       err
);

  localparam logic [3:0] TERM_H = 4'((TERM / 100) % 10);
  localparam logic [3:0] TERM_T = 4'((TERM / 10) % 10);
  localparam logic [3:0] TERM_O = 4'(TERM % 10);

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  logic [3:0] wh_q, wh_d, wt_q, wt_d, wo_q, wo_d;
  logic [3:0] dh_q, dh_d, dt_q, dt_d, do_q, do_d;
  logic       c1_q, c1_d, c2_q, c2_d, tc_q, tc_d;
  logic       wrap_q, wrap_d, err_q, err_d;
  logic       dir_q, dir_d;
  logic       dir;
  logic       multi;
  logic       at_term, at_zero;

  // ph[0] uses dn directly so the whole sequence, including the
  // first step, follows the direction captured at that phase.
`ifdef CNT_DOWN_EN
  assign dir = ph[0] ? dn : dir_q;
`else
  assign dir = 1'b0;
`endif

  assign multi   = (ph & (ph - 5'd1)) != 5'd0;
  assign at_term = (wh_q == TERM_H) && (wt_q == TERM_T) && (wo_q == TERM_O);
  assign at_zero = (wh_q == 4'd0) && (wt_q == 4'd0) && (wo_q == 4'd0);

  always_comb begin
    wh_d   = wh_q;
    wt_d   = wt_q;
    wo_d   = wo_q;
    dh_d   = dh_q;
    dt_d   = dt_q;
    do_d   = do_q;
    c1_d   = c1_q;
    c2_d   = c2_q;
    tc_d   = tc_q;
    err_d  = err_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (clr) begin
      wh_d  = 4'd0;
      wt_d  = 4'd0;
      wo_d  = 4'd0;
      dh_d  = 4'd0;
      dt_d  = 4'd0;
      do_d  = 4'd0;
      c1_d  = 1'b0;
      c2_d  = 1'b0;
      tc_d  = 1'b0;
      err_d = 1'b0;
      dir_d = 1'b0;
    end else if (ph == 5'd0) begin
      // idle
    end else if (multi) begin
      err_d = 1'b1;
    end else begin
      unique case (1'b1)
        ph[0]: begin
          dir_d = dir;
          if (dir) begin
            tc_d = at_zero;
            c1_d = (wo_q == 4'd0);
            wo_d = bcd_dec(wo_q);
          end else begin
            tc_d = at_term;
            c1_d = (wo_q == 4'd9);
            wo_d = bcd_inc(wo_q);
          end
        end
        ph[1]: begin
          c2_d = 1'b0;
          if (c1_q) begin
            c2_d = dir ? (wt_q == 4'd0) : (wt_q == 4'd9);
            wt_d = dir ? bcd_dec(wt_q) : bcd_inc(wt_q);
          end
        end
        ph[2]: begin
          if (c2_q)
            wh_d = dir ? bcd_dec(wh_q) : bcd_inc(wh_q);
        end
        ph[3]: begin
          if (tc_q) begin
            wrap_d = 1'b1;
            wh_d   = dir ? TERM_H : 4'd0;
            wt_d   = dir ? TERM_T : 4'd0;
            wo_d   = dir ? TERM_O : 4'd0;
          end
          c1_d = 1'b0;
          c2_d = 1'b0;
          tc_d = 1'b0;
        end
        ph[4]: begin
          dh_d = wh_q;
          dt_d = wt_q;
          do_d = wo_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wh_q   <= 4'd0;
      wt_q   <= 4'd0;
      wo_q   <= 4'd0;
      dh_q   <= 4'd0;
      dt_q   <= 4'd0;
      do_q   <= 4'd0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      wh_q   <= wh_d;
      wt_q   <= wt_d;
      wo_q   <= wo_d;
      dh_q   <= dh_d;
      dt_q   <= dt_d;
      do_q   <= do_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      dir_q  <= dir_d;
    end
  end

  assign disp_h = dh_q;
  assign disp_t = dt_q;
  assign disp_o = do_q;
  assign wrap   = wrap_q;
  assign err    = err_q;

endmodule

// File: tb/tb_phase_bcd_counter.sv
// tb_phase_bcd_counter: directed sequences plus random phases,
// every cycle compared with a digit-level reference model.
module tb_phase_bcd_counter;

  localparam int TERM = 499;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [4:0] ph  = 5'd0;
  logic       clr = 1'b0;
  logic       dn  = 1'b0;
  logic [3:0] disp_h, disp_t, disp_o;
  logic       wrap, err;

  int errs   = 0;
  int checks = 0;
  int wrap_seen = 0;

  // reference model state; index 0 = ones digit
  int m_w[3];
  int m_disp;
  int m_c1, m_c2, m_tc, m_wrap, m_err, m_dir;

  always #5 CLK = ~CLK;

  phase_bcd_counter #(.TERM(TERM)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .ph     (ph),
    .clr    (clr),
`ifdef CNT_DOWN_EN
    .dn     (dn),
`endif
    .disp_h (disp_h),
    .disp_t (disp_t),
    .disp_o (disp_o),
    .wrap   (wrap),
    .err    (err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int disp_val();
    return int'(disp_h) * 100 + int'(disp_t) * 10 + int'(disp_o);
  endfunction

  function automatic int wval();
    return m_w[2] * 100 + m_w[1] * 10 + m_w[0];
  endfunction

  // next value of digit k when stepping in direction m_dir
  function automatic int dstep(input int k);
    return m_dir != 0 ? (m_w[k] + 9) % 10 : (m_w[k] + 1) % 10;
  endfunction

  function automatic int edge_digit();
    return m_dir != 0 ? 0 : 9;
  endfunction

  task automatic model(input logic [4:0] p, input logic c,
                       input logic d, input logic r);
    int nbits;
    if (r || c) begin
      m_w = '{0, 0, 0};
      m_disp = 0;
      {m_c1, m_c2, m_tc, m_wrap, m_err, m_dir} = '0;
      return;
    end
    m_wrap = 0;
    nbits = $countones(p);
    if (nbits > 1) begin
      m_err = 1;
    end else if (nbits == 1) begin
      if (p[0]) begin
`ifdef CNT_DOWN_EN
        m_dir = int'(d);
`else
        m_dir = 0;
        if (d) m_dir = 0;
`endif
        m_tc = (wval() == (m_dir != 0 ? 0 : TERM)) ? 1 : 0;
        m_c1 = (m_w[0] == edge_digit()) ? 1 : 0;
        m_w[0] = dstep(0);
      end else if (p[1]) begin
        if (m_c1 != 0) begin
          m_c2 = (m_w[1] == edge_digit()) ? 1 : 0;
          m_w[1] = dstep(1);
        end else m_c2 = 0;
      end else if (p[2]) begin
        if (m_c2 != 0) m_w[2] = dstep(2);
      end else if (p[3]) begin
        if (m_tc != 0) begin
          m_wrap = 1;
          if (m_dir != 0)
            m_w = '{TERM % 10, (TERM / 10) % 10, (TERM / 100) % 10};
          else
            m_w = '{0, 0, 0};
        end
        m_c1 = 0;
        m_c2 = 0;
        m_tc = 0;
      end else begin
        m_disp = wval();
      end
    end
  endtask

  task automatic step(input logic [4:0] p, input logic c,
                      input logic d, input logic r);
    ph  = p;
    clr = c;
    dn  = d;
    RST = r;
    @(posedge CLK);
    model(p, c, d, r);
    #1;
    if (wrap) wrap_seen++;
    chk("disp", disp_val(), m_disp);
    chk("wrap", int'(wrap), m_wrap);
    chk("err", int'(err), m_err);
  endtask

  task automatic seq(input logic d);
    for (int k = 0; k < 5; k++) step(5'(1 << k), 1'b0, d, 1'b0);
  endtask

  task automatic seqs(input int n, input logic d);
    for (int i = 0; i < n; i++) seq(d);
  endtask

  initial begin
    logic [4:0] rp;
    int sel;
    step(5'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_disp", disp_val(), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_err", int'(err), 0);

    // 1: five sequences
    wrap_seen = 0;
    seqs(5, 1'b0);
    chk("five", disp_val(), 5);
    chk("no_wrap", wrap_seen, 0);
    chk("no_err", int'(err), 0);

    // 2: carries into tens and hundreds
    seqs(4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(5'(1 << k), 1'b0, 1'b0, 1'b0);
      chk("hold9", disp_val(), 9);
    end
    step(5'b10000, 1'b0, 1'b0, 1'b0);
    chk("ten", disp_val(), 10);
    seqs(89, 1'b0);
    chk("n99", disp_val(), 99);
    seq(1'b0);
    chk("hundred", disp_val(), 100);

    // 3: terminal count and wrap
    seqs(TERM - 100, 1'b0);
    chk("term", disp_val(), TERM);
    for (int k = 0; k < 4; k++) step(5'(1 << k), 1'b0, 1'b0, 1'b0);
    chk("wrap_hi", int'(wrap), 1);
    step(5'b10000, 1'b0, 1'b0, 1'b0);
    chk("wrap_lo", int'(wrap), 0);
    chk("wrapped", disp_val(), 0);

    // 4: clear mid-sequence
    seqs(123, 1'b0);
    chk("n123", disp_val(), 123);
    step(5'b00001, 1'b0, 1'b0, 1'b0);
    step(5'b00010, 1'b0, 1'b0, 1'b0);
    step(5'b00100, 1'b1, 1'b0, 1'b0);
    chk("clr_disp", disp_val(), 0);
    step(5'b01000, 1'b0, 1'b0, 1'b0);
    chk("clr_wrap", int'(wrap), 0);
    step(5'b10000, 1'b0, 1'b0, 1'b0);
    chk("clr_latch", disp_val(), 0);
    seq(1'b0);
    chk("after_clr", disp_val(), 1);

    // 5: multi-hot phase
    seqs(41, 1'b0);
    step(5'b00011, 1'b0, 1'b0, 1'b0);
    chk("mh_disp", disp_val(), 42);
    chk("mh_err", int'(err), 1);
    seqs(3, 1'b0);
    chk("mh_cont", disp_val(), 45);
    chk("err_sticky", int'(err), 1);
    step(5'd0, 1'b1, 1'b0, 1'b0);
    chk("err_clr", int'(err), 0);

`ifdef CNT_DOWN_EN
    // 6: down counting
    for (int k = 0; k < 4; k++) step(5'(1 << k), 1'b0, 1'b1, 1'b0);
    chk("dn_wrap", int'(wrap), 1);
    step(5'b10000, 1'b0, 1'b1, 1'b0);
    chk("dn_term", disp_val(), TERM);
    seq(1'b1);
    chk("dn_498", disp_val(), TERM - 1);
    seqs(102, 1'b0);
    chk("up_100", disp_val(), 100);
    seq(1'b1);
    chk("dn_99", disp_val(), 99);
`endif

    // random phases, clears and occasional multi-hot vectors
    for (int i = 0; i < 2500; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 10) rp = 5'd0;
      else if (sel < 13) rp = 5'($urandom_range(0, 31));
      else if (sel < 75) rp = 5'(1 << (i % 5));
      else rp = 5'(1 << $urandom_range(0, 4));
      step(rp, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
